// File: rtl/s820_pkg.sv
// s820_pkg -- shared types and constants for the s820 state sequencer.
//   state_e            : sequencer FSM states (IDLE, APPLY, CAPTURE, HOLD)
//   PI_W / ST_W / PO_W : primary-input, state and primary-output widths
//   G38_IDX..G42_IDX   : bit positions of the state bits within cone_state
package s820_pkg;

  localparam int PI_W = 18;
  localparam int ST_W = 5;
  localparam int PO_W = 19;

  // cone_state = {G42,G41,G40,G39,G38}, G38 is the LSB
  localparam int G38_IDX = 0;
  localparam int G39_IDX = 1;
  localparam int G40_IDX = 2;
  localparam int G41_IDX = 3;
  localparam int G42_IDX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/s820_state_reg.sv
// s820_state_reg -- 5-bit circuit state register {G42..G38}.
//   CK, RST   : clock, asynchronous active-high reset (loads INIT)
//   load_en   : parallel-load load_val (the cone next-state bits)
//   load_val  : next-state value
//   scan_en   : (S820_SCAN_EN only) shift one bit per cycle, overrides load
//   scan_in   : (S820_SCAN_EN only) serial input, enters G38
//   scan_out  : (S820_SCAN_EN only) serial output, taken from G42
//   state     : current register contents
// Optional feature macro: S820_SCAN_EN.
module s820_state_reg
  import s820_pkg::*;
#(
  parameter logic [ST_W-1:0] INIT = '0
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            load_en,
  input  logic [ST_W-1:0] load_val,
`ifdef S820_SCAN_EN
  input  logic            scan_en,
  input  logic            scan_in,
  output logic            scan_out,
`endif
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
`ifdef S820_SCAN_EN
    if (scan_en)
      state_d = {state_q[ST_W-2:0], scan_in};
    else
`endif
    if (load_en)
      state_d = load_val;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= INIT;
    else     state_q <= state_d;
  end

  assign state = state_q;
`ifdef S820_SCAN_EN
  assign scan_out = state_q[G42_IDX];
`endif

endmodule

// File: rtl/s820_state_seq.sv
// s820_state_seq -- vector sequencer around the external s820 combinational
// cones. A PI vector is accepted in IDLE, held for one settle cycle (APPLY),
// the cone next-state and outputs are captured in CAPTURE, and the response
// is held in HOLD until the consumer takes it.
//   CK, RST            : clock, asynchronous active-high reset
//   pi_vec/pi_valid    : input vector handshake, pi_ready high only in IDLE
//   cone_pi/cone_state : registered drive into the cones
//   ns_in/po_in        : cone next-state and primary outputs
//   po_out/po_valid    : captured response, released by po_ready in HOLD
//   vec_count          : completed vectors, wraps modulo 2^CNT_W
//   scan_en/in/out     : (S820_SCAN_EN only) serial access to cone_state;
//                        while scan_en is high everything else freezes
// Optional feature macro: S820_SCAN_EN.
module s820_state_seq
  import s820_pkg::*;
#(
  parameter logic [ST_W-1:0] STATE_INIT = 5'b00000,
  parameter int              CNT_W      = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [PI_W-1:0]  pi_vec,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic [PI_W-1:0]  cone_pi,
  output logic [ST_W-1:0]  cone_state,
  input  logic [ST_W-1:0]  ns_in,
  input  logic [PO_W-1:0]  po_in,
  output logic [PO_W-1:0]  po_out,
  output logic             po_valid,
  input  logic             po_ready,
`ifdef S820_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  output logic [CNT_W-1:0] vec_count
);

  state_e            state_d, state_q;
  logic [PI_W-1:0]   cone_pi_d, cone_pi_q;
  logic [PO_W-1:0]   po_out_d, po_out_q;
  logic              po_valid_d, po_valid_q;
  logic              pi_ready_d, pi_ready_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              st_load;
  logic              freeze;

`ifdef S820_SCAN_EN
  assign freeze = scan_en;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cone_pi_d  = cone_pi_q;
    po_out_d   = po_out_q;
    po_valid_d = po_valid_q;
    cnt_d      = cnt_q;
    st_load    = 1'b0;
    if (!freeze) begin
      case (state_q)
        IDLE: if (pi_valid) begin
          cone_pi_d = pi_vec;
          state_d   = APPLY;
        end
        // cones settle on the held cone_pi/cone_state
        APPLY: state_d = CAPTURE;
        CAPTURE: begin
          st_load    = 1'b1;
          po_out_d   = po_in;
          po_valid_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          state_d    = HOLD;
        end
        // po_ready only matters here; leaving always passes through IDLE
        HOLD: if (po_ready) begin
          po_valid_d = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    pi_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cone_pi_q  <= '0;
      po_out_q   <= '0;
      po_valid_q <= 1'b0;
      pi_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cone_pi_q  <= cone_pi_d;
      po_out_q   <= po_out_d;
      po_valid_q <= po_valid_d;
      pi_ready_q <= pi_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  s820_state_reg #(.INIT(STATE_INIT)) u_state_reg (
    .CK       (CK),
    .RST      (RST),
    .load_en  (st_load),
    .load_val (ns_in),
`ifdef S820_SCAN_EN
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
`endif
    .state    (cone_state)
  );

  assign cone_pi   = cone_pi_q;
  assign po_out    = po_out_q;
  assign po_valid  = po_valid_q;
  assign pi_ready  = pi_ready_q & ~freeze;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_s820_state_seq.sv
// tb_s820_state_seq -- directed self-checking bench for s820_state_seq
// (CNT_W = 4 so that counter wrap is reached quickly). Scan checks are
// compiled in only when S820_SCAN_EN is defined.
module tb_s820_state_seq;
  import s820_pkg::*;

  logic            CK = 1'b0;
  logic            RST;
  logic [PI_W-1:0] pi_vec;
  logic            pi_valid;
  logic            pi_ready;
  logic [PI_W-1:0] cone_pi;
  logic [ST_W-1:0] cone_state;
  logic [ST_W-1:0] ns_in;
  logic [PO_W-1:0] po_in;
  logic [PO_W-1:0] po_out;
  logic            po_valid;
  logic            po_ready;
  logic [3:0]      vec_count;
`ifdef S820_SCAN_EN
  logic            scan_en;
  logic            scan_in;
  logic            scan_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CK = ~CK;

  s820_state_seq #(.STATE_INIT(5'b00000), .CNT_W(4)) dut (
    .CK         (CK),
    .RST        (RST),
    .pi_vec     (pi_vec),
    .pi_valid   (pi_valid),
    .pi_ready   (pi_ready),
    .cone_pi    (cone_pi),
    .cone_state (cone_state),
    .ns_in      (ns_in),
    .po_in      (po_in),
    .po_out     (po_out),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
`ifdef S820_SCAN_EN
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
`endif
    .vec_count  (vec_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; outputs are settled 1ns later
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // one full vector: accept, settle, capture, release
  task automatic run_vec(input logic [PI_W-1:0] v, input logic [ST_W-1:0] ns,
                         input logic [PO_W-1:0] po);
    pi_vec = v; pi_valid = 1'b1; ns_in = ns; po_in = po;
    tick();
    pi_valid = 1'b0;
    tick();
    tick();
    chk("vec_po_valid", 32'(po_valid), 32'd1);
    chk("vec_po_out", 32'(po_out), 32'(po));
    chk("vec_state", 32'(cone_state), 32'(ns));
    po_ready = 1'b1;
    tick();
    po_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; pi_vec = '0; pi_valid = 1'b0; ns_in = '0; po_in = '0; po_ready = 1'b0;
`ifdef S820_SCAN_EN
    scan_en = 1'b0; scan_in = 1'b0;
`endif
    #22 RST = 1'b0;
    #1;
    chk("rst_state", 32'(cone_state), 32'h00);
    chk("rst_pi_ready", 32'(pi_ready), 32'd1);
    chk("rst_po_valid", 32'(po_valid), 32'd0);
    chk("rst_count", 32'(vec_count), 32'd0);
    chk("rst_cone_pi", 32'(cone_pi), 32'd0);
    chk("rst_po_out", 32'(po_out), 32'd0);

    // vector 1: accept edge
    pi_vec = 18'h2AAAA; pi_valid = 1'b1; ns_in = 5'b10110; po_in = 19'h5A5A5;
    tick();
    chk("acc_cone_pi", 32'(cone_pi), 32'h2AAAA);
    chk("acc_pi_ready", 32'(pi_ready), 32'd0);
    // in APPLY: different pi_vec with pi_valid and a stray po_ready
    pi_vec = 18'h3FFFF; pi_valid = 1'b1; po_ready = 1'b1;
    tick();
    chk("apply_po_valid", 32'(po_valid), 32'd0);
    chk("apply_state", 32'(cone_state), 32'h00);
    chk("apply_cone_pi", 32'(cone_pi), 32'h2AAAA);
    po_ready = 1'b0;
    tick();
    chk("cap_po_valid", 32'(po_valid), 32'd1);
    chk("cap_po_out", 32'(po_out), 32'h5A5A5);
    chk("cap_state", 32'(cone_state), 32'b10110);
    chk("cap_count", 32'(vec_count), 32'd1);

    // HOLD with po_ready low: everything stable while cone inputs change
    po_in = 19'h00000; ns_in = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_po_out", 32'(po_out), 32'h5A5A5);
      chk("hold_pi_ready", 32'(pi_ready), 32'd0);
      chk("hold_po_valid", 32'(po_valid), 32'd1);
      chk("hold_state", 32'(cone_state), 32'b10110);
      chk("hold_cone_pi", 32'(cone_pi), 32'h2AAAA);
    end

    // release with pi_valid already high: must land in IDLE, not accept
    pi_vec = 18'h15555; pi_valid = 1'b1; po_ready = 1'b1;
    tick();
    chk("rel_po_valid", 32'(po_valid), 32'd0);
    chk("rel_pi_ready", 32'(pi_ready), 32'd1);
    chk("rel_cone_pi", 32'(cone_pi), 32'h2AAAA);
    chk("rel_count", 32'(vec_count), 32'd1);
    po_ready = 1'b0;
    tick();
    chk("acc2_cone_pi", 32'(cone_pi), 32'h15555);
    chk("acc2_pi_ready", 32'(pi_ready), 32'd0);
    pi_valid = 1'b0; ns_in = 5'b01001; po_in = 19'h12345;
    tick();
    // now in CAPTURE: reset aborts the vector
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("abort_state", 32'(cone_state), 32'h00);
    chk("abort_count", 32'(vec_count), 32'd0);
    chk("abort_po_valid", 32'(po_valid), 32'd0);
    chk("abort_pi_ready", 32'(pi_ready), 32'd1);
    chk("abort_cone_pi", 32'(cone_pi), 32'd0);
    chk("abort_po_out", 32'(po_out), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("abort_idle_po_valid", 32'(po_valid), 32'd0);
    chk("abort_idle_state", 32'(cone_state), 32'h00);

    // 17 vectors through a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      run_vec(18'(i * 18'h0123B), 5'(i), 19'(i * 19'h01F3D));
      chk("loop_pi_ready", 32'(pi_ready), 32'd1);
      if (i == 15) chk("count_15", 32'(vec_count), 32'd15);
      if (i == 16) chk("count_wrap", 32'(vec_count), 32'd0);
    end
    chk("count_17", 32'(vec_count), 32'd1);
    chk("last_state", 32'(cone_state), 32'b10001);

`ifdef S820_SCAN_EN
    begin
      logic [4:0] bits;
      logic [4:0] prev;
      bits = 5'b10110;
      prev = cone_state;
      scan_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        scan_in = bits[4-i];
        #1;
        chk("scan_pi_ready", 32'(pi_ready), 32'd0);
        chk("scan_out", 32'(scan_out), 32'(prev[4-i]));
        tick();
      end
      scan_en = 1'b0;
      chk("scan_state", 32'(cone_state), 32'b10110);
      chk("scan_count", 32'(vec_count), 32'd1);
      chk("scan_po_valid", 32'(po_valid), 32'd0);
      chk("scan_after_pi_ready", 32'(pi_ready), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s820_state_seq.md
S820_STATE_SEQ -- requirements
Module: s820_state_seq

Interface
REQ-001 The block SHALL have parameter STATE_INIT, default 5'b00000, giving the reset value of state bits {G42,G41,G40,G39,G38}.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the vector counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports CK and RST.
REQ-004 CK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 pi_vec  input  18  primary-input vector, bit order G0..G16, G18 (LSB = G0).
REQ-007 pi_valid  input  1  pi_vec is valid.
REQ-008 pi_ready  output  1  block accepts pi_vec this cycle.
REQ-009 cone_pi  output  18  registered PI vector driven to the combinational cones.
REQ-010 cone_state  output  5  current state {G42,G41,G40,G39,G38} driven to the cones.
REQ-011 ns_in  input  5  next-state bits returned by the cones (n95 and sibling cones), same bit order.
REQ-012 po_in  input  19  primary outputs returned by the cones.
REQ-013 po_out  output  19  captured primary-output response.
REQ-014 po_valid  output  1  po_out is valid.
REQ-015 po_ready  input  1  consumer accepts po_out.
REQ-016 vec_count  output  CNT_W  number of completed vectors.

Function
REQ-017 The FSM SHALL have the states IDLE, APPLY, CAPTURE and HOLD.
REQ-018 pi_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, when pi_valid is 1: the block SHALL register pi_vec into cone_pi and go to APPLY; when pi_valid is 0 it SHALL stay in IDLE.
REQ-020 APPLY SHALL last exactly one cycle, which is the cone settle cycle; cone_pi and cone_state SHALL be held stable.
REQ-021 In CAPTURE, on one edge, the block SHALL load ns_in into cone_state, load po_in into po_out, set po_valid, increment vec_count and go to HOLD.
REQ-022 In HOLD, po_valid SHALL be 1 and po_out SHALL be stable; when po_ready is 1 the block SHALL clear po_valid and go to IDLE.
REQ-023 Latency from pi_valid&pi_ready to po_valid SHALL be exactly 3 edges.
REQ-024 A po_ready asserted outside HOLD SHALL be ignored.
REQ-025 The minimum throughput SHALL be one vector per 4 cycles; back-to-back acceptance in the cycle po_ready is seen SHALL NOT occur (IDLE is always visited).
REQ-026 vec_count SHALL wrap modulo 2^CNT_W with no saturation and no flag.
REQ-027 cone_state SHALL change only in CAPTURE; pi_valid toggling in APPLY, CAPTURE or HOLD SHALL have no effect.

Reset
REQ-028 On RST: FSM = IDLE, cone_state = STATE_INIT, cone_pi = 0, po_out = 0, po_valid = 0, vec_count = 0, pi_ready = 1 once RST deasserts.
REQ-029 RST asserted mid-operation (APPLY, CAPTURE or HOLD) SHALL abort the vector; no partial capture or count increment is retained.

Configuration
REQ-030 When macro S820_SCAN_EN is defined, the block SHALL add ports scan_en (input 1), scan_in (input 1) and scan_out (output 1).
REQ-031 With S820_SCAN_EN and scan_en = 1, cone_state SHALL shift one bit per cycle: scan_in enters G38, G42 leaves on scan_out; the FSM and all other registers SHALL freeze, and pi_ready SHALL be 0.
REQ-032 With S820_SCAN_EN and scan_en = 0, the block SHALL behave as in REQ-017..027.
REQ-033 Without S820_SCAN_EN, the scan ports and shift logic SHALL be absent and behaviour SHALL be exactly REQ-017..027.

Structure
REQ-034 Package s820_pkg SHALL hold the FSM state enum, the widths PI_W=18, ST_W=5 and PO_W=19, and the bit-index constants for G38..G42.
REQ-035 One sub-module, s820_state_reg, SHALL hold the 5-bit state register with its parallel-load and optional scan shift; the FSM, PI/PO registers and counter SHALL live in the top.

Verification
REQ-036 After reset: cone_state = 00000, pi_ready = 1, po_valid = 0, vec_count = 0.
REQ-037 pi_vec = 18'h2AAAA with pi_valid for 1 cycle, ns_in = 5'b10110, po_in = 19'h5A5A5 -> po_valid rises 3 edges later, po_out = 19'h5A5A5, cone_state = 10110, vec_count = 1.
REQ-038 po_ready held 0 for 5 cycles in HOLD -> po_out stable and pi_ready = 0 throughout; po_ready = 1 -> IDLE next edge and pi_ready = 1.
REQ-039 RST pulsed during CAPTURE -> cone_state = STATE_INIT, vec_count unchanged from 0, po_valid = 0.
REQ-040 CNT_W = 4, run 17 vectors -> vec_count = 1.
REQ-041 With S820_SCAN_EN: shift scan_in = 1,0,1,1,0 over 5 cycles -> cone_state = {G42..G38} = 10110, and scan_out presents the previous state MSB-first.
